pipeline_run_ctrl: RTL and testbench
====================================

PIPELINE_RUN_CTRL -- requirements
Module: pipeline_run_ctrl

Interface
REQ-001 Parameter RUN_DIV, default 100000: clk cycles per pipe_en pulse in RUN; legal range 2..2^24.
REQ-002 Parameter CNT_W, default 32: width of cycle_cnt.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 step_btn  input  1  debounced step-button level.
REQ-006 run_sw  input  1  run-mode switch level.
REQ-007 halt_req  input  1  external halt request, level.
REQ-008 bp_en  input  1  breakpoint enable.
REQ-009 bp_pc  input  32  breakpoint PC.
REQ-010 pc_f  input  32  current fetch-stage PC.
REQ-011 pipe_en  output  1  registered clock-enable to all pipeline stage registers; one-cycle pulses only.
REQ-012 state  output  2  FSM state: HALT=0, STEP=1, RUN=2, BREAK=3.
REQ-013 halted  output  1  high when state is HALT or BREAK.
REQ-014 cycle_cnt  output  CNT_W  count of issued pipe_en pulses.

Function
REQ-015 Edge detect: step_rise = step_btn high and previous-cycle step_btn low; run_rise likewise for run_sw.
REQ-016 HALT: run_rise -> RUN; else step_rise -> STEP; run_rise and step_rise together -> RUN, step ignored.
REQ-017 STEP: pipe_en high for exactly this one cycle; next state HALT unconditionally.
REQ-018 RUN: divider counts 0..RUN_DIV-1 and wraps to 0; pipe_en asserted in the cycle after divider equals RUN_DIV-1.
REQ-019 RUN exit priority: halt_req -> HALT, then breakpoint -> BREAK, then run_sw low -> HALT; every exit clears the divider to 0 and suppresses any pending pipe_en.
REQ-020 Breakpoint hit: in RUN, when divider equals RUN_DIV-1, bp_en is high and pc_f equals bp_pc, pipe_en is not issued and the next state is BREAK.
REQ-021 BREAK: step_rise -> STEP, with no breakpoint check, so execution advances past bp_pc; else run_sw low -> HALT; otherwise hold.
REQ-022 Breakpoint compare applies only in RUN; STEP never checks it.
REQ-023 Re-entering RUN requires a new run_rise; run_sw held high after BREAK or halt_req does not restart RUN.
REQ-024 halt_req high in HALT, STEP or BREAK has no effect; a STEP in progress completes.
REQ-025 cycle_cnt increments by 1 in the cycle after each pipe_en pulse and wraps from 2^CNT_W-1 to 0.
REQ-026 pipe_en is never high in two consecutive cycles.

Reset
REQ-027 When rst is high at a clk edge, state=HALT, pipe_en=0, halted=1, cycle_cnt=0, divider=0, and both edge-detect history registers capture the current input levels.
REQ-028 Reset mid-RUN or mid-STEP aborts with no further pipe_en; a button or switch held through reset produces no edge afterwards.

Structure
REQ-029 State encodings (HALT, STEP, RUN, BREAK) are defined in the shared pipeline package; RUN_DIV and CNT_W stay module parameters.
REQ-030 Edge detection is one sub-module, edge_rise, instantiated twice (step_btn, run_sw); the FSM, divider and counter stay flat.

Verification
REQ-031 RUN_DIV=4, rst then step_btn 0->1: exactly one pipe_en, 2 cycles after the edge; cycle_cnt=1; state returns to HALT.
REQ-032 RUN_DIV=4, run_sw 0->1 held 20 cycles: pipe_en on every 4th cycle, never consecutive; cycle_cnt=4 or 5.
REQ-033 RUN_DIV=4, bp_en=1, bp_pc=0x10, pc_f=0x10 at the first enable point: no pipe_en, state=BREAK; then step_rise: one pipe_en, state HALT.
REQ-034 RUN with halt_req and breakpoint both true in the same cycle: state=HALT (not BREAK), no pipe_en; run_sw still high causes no restart.
REQ-035 CNT_W=4, 16 steps from cycle_cnt=0: cycle_cnt wraps to 0; rst asserted during RUN: next cycle state=HALT, pipe_en=0, cycle_cnt=0.

Source files
------------

// File: rtl/pipeline_run_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_run_ctrl_pkg                                                |
// | Shared state encodings and helpers for the pipeline run controller.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pipeline_run_ctrl_pkg;

    localparam logic [1:0] c_state_halt  = 2'd0;
    localparam logic [1:0] c_state_step  = 2'd1;
    localparam logic [1:0] c_state_run   = 2'd2;
    localparam logic [1:0] c_state_break = 2'd3;

    function automatic logic is_halted(input logic [1:0] s);
        return (s == c_state_halt) || (s == c_state_break);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_run_ctrl_edge_rise.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_rise                                                            |
// | Rising-edge detector on a level input (one-cycle history register).  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module edge_rise
    import pipeline_run_ctrl_pkg::*;
(
    input  logic clk,
    input  logic i_din,
    output logic o_rise
);

    logic r_prev;

    // History always tracks the input, so a level held through reset is
    // already captured and never reads as a fresh edge afterwards.
    always_ff @(posedge clk) begin
        r_prev <= i_din;
    end

    assign o_rise = i_din & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/pipeline_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_run_ctrl                                                    |
// | HALT/STEP/RUN/BREAK controller issuing pipe_en pulses to a pipeline. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipeline_run_ctrl
    import pipeline_run_ctrl_pkg::*;
#(
    parameter int RUN_DIV = 100000,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_btn,
    input  logic             run_sw,
    input  logic             halt_req,
    input  logic             bp_en,
    input  logic [31:0]      bp_pc,
    input  logic [31:0]      pc_f,
    output logic             pipe_en,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int                 c_div_w   = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_max = c_div_w'(RUN_DIV - 1);

    logic [1:0]         r_state;
    logic               r_pipe_en;
    logic [c_div_w-1:0] r_div;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic               w_step_rise;
    logic               w_run_rise;
    logic               w_div_wrap;
    logic               w_bp_hit;

    edge_rise u_step_edge (
        .clk    (clk),
        .i_din  (step_btn),
        .o_rise (w_step_rise)
    );

    edge_rise u_run_edge (
        .clk    (clk),
        .i_din  (run_sw),
        .o_rise (w_run_rise)
    );

    assign w_div_wrap = (r_div == c_div_max);
    assign w_bp_hit   = w_div_wrap && bp_en && (pc_f == bp_pc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_state_halt;
            r_pipe_en   <= 1'b0;
            r_div       <= '0;
            r_cycle_cnt <= '0;
        end else begin
            r_pipe_en <= 1'b0;
            if (r_pipe_en) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            case (r_state)
                c_state_halt: begin
                    // A simultaneous step press is dropped in favour of RUN.
                    if (w_run_rise) begin
                        r_state <= c_state_run;
                        r_div   <= '0;
                    end else if (w_step_rise) begin
                        r_state <= c_state_step;
                    end
                end
                c_state_step: begin
                    r_pipe_en <= 1'b1;
                    r_state   <= c_state_halt;
                end
                c_state_run: begin
                    if (halt_req) begin
                        r_state <= c_state_halt;
                        r_div   <= '0;
                    end else if (w_bp_hit) begin
                        r_state <= c_state_break;
                        r_div   <= '0;
                    end else if (!run_sw) begin
                        r_state <= c_state_halt;
                        r_div   <= '0;
                    end else begin
                        r_div     <= w_div_wrap ? '0 : r_div + c_div_w'(1);
                        r_pipe_en <= w_div_wrap;
                    end
                end
                c_state_break: begin
                    // Stepping out skips the compare so execution moves past bp_pc.
                    if (w_step_rise) begin
                        r_state <= c_state_step;
                    end else if (!run_sw) begin
                        r_state <= c_state_halt;
                    end
                end
                default: r_state <= c_state_halt;
            endcase
        end
    end

    assign pipe_en   = r_pipe_en;
    assign state     = r_state;
    assign halted    = is_halted(r_state);
    assign cycle_cnt = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipeline_run_ctrl                                                 |
// | Directed self-checking bench, RUN_DIV=4, CNT_W=4.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pipeline_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        step_btn;
    logic        run_sw;
    logic        halt_req;
    logic        bp_en;
    logic [31:0] bp_pc;
    logic [31:0] pc_f;
    logic        pipe_en;
    logic [1:0]  state;
    logic        halted;
    logic [3:0]  cycle_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;
    logic prev_en;

    pipeline_run_ctrl #(.RUN_DIV(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .step_btn  (step_btn),
        .run_sw    (run_sw),
        .halt_req  (halt_req),
        .bp_en     (bp_en),
        .bp_pc     (bp_pc),
        .pc_f      (pc_f),
        .pipe_en   (pipe_en),
        .state     (state),
        .halted    (halted),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; step_btn = 1'b0; run_sw = 1'b0; halt_req = 1'b0;
        bp_en = 1'b0; bp_pc = 32'h10; pc_f = 32'h0;
        tick(); tick();
        check("rst_state", state, 0);
        check("rst_pipe_en", pipe_en, 0);
        check("rst_halted", halted, 1);
        check("rst_cnt", cycle_cnt, 0);
        rst = 1'b0;
        tick();

        // single step
        step_btn = 1'b1;
        tick();
        check("step_state", state, 1);
        check("step_en_early", pipe_en, 0);
        tick();
        check("step_en", pipe_en, 1);
        check("step_back_halt", state, 0);
        check("step_cnt_pre", cycle_cnt, 0);
        tick();
        check("step_en_off", pipe_en, 0);
        check("step_cnt", cycle_cnt, 1);
        step_btn = 1'b0;
        tick();

        // free run: pulses after edges 5, 9, 13, 17
        rst = 1'b1; tick(); rst = 1'b0;
        run_sw = 1'b1;
        pulses = 0; prev_en = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("run_en", pipe_en, (i >= 5 && ((i - 5) % 4) == 0) ? 1 : 0);
            check("run_no_consec", prev_en & pipe_en, 0);
            if (pipe_en) pulses++;
            prev_en = pipe_en;
        end
        check("run_pulses", pulses, 4);
        check("run_cnt", cycle_cnt, 4);
        check("run_state", state, 2);
        check("run_not_halted", halted, 0);
        run_sw = 1'b0;
        tick();
        check("runoff_state", state, 0);
        check("runoff_suppressed", pipe_en, 0);
        tick();
        check("runoff_cnt", cycle_cnt, 4);

        // breakpoint at first enable point
        bp_en = 1'b1; pc_f = 32'h10; run_sw = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("bp_no_en", pipe_en, 0);
        end
        check("bp_state", state, 3);
        check("bp_halted", halted, 1);
        tick();
        check("bp_hold", state, 3);
        check("bp_cnt", cycle_cnt, 4);
        step_btn = 1'b1;
        tick();
        check("bp_step_state", state, 1);
        tick();
        check("bp_step_en", pipe_en, 1);
        check("bp_step_halt", state, 0);
        tick();
        check("bp_step_cnt", cycle_cnt, 5);
        step_btn = 1'b0;
        tick();
        check("bp_no_restart", state, 0);

        // halt_req beats breakpoint in the same cycle
        run_sw = 1'b0; tick();
        run_sw = 1'b1; tick();
        check("hr_run", state, 2);
        tick(); tick(); tick();
        halt_req = 1'b1;
        tick();
        check("hr_state", state, 0);
        check("hr_no_en", pipe_en, 0);
        halt_req = 1'b0;
        tick(); tick();
        check("hr_no_restart", state, 0);
        check("hr_cnt", cycle_cnt, 5);

        // halt_req ignored in HALT; step completes
        halt_req = 1'b1; step_btn = 1'b1;
        tick();
        check("hr_step_state", state, 1);
        tick();
        check("hr_step_en", pipe_en, 1);
        halt_req = 1'b0; step_btn = 1'b0;
        tick();
        check("hr_step_cnt", cycle_cnt, 6);

        // counter wrap with 16 steps
        bp_en = 1'b0; run_sw = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step_btn = 1'b1; tick();
            step_btn = 1'b0; tick();
            tick();
            check("wrap_cnt", cycle_cnt, (i + 1) % 16);
        end

        // reset mid-RUN with run_sw held
        run_sw = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        check("rrun_en", pipe_en, 1);
        tick();
        check("rrun_cnt", cycle_cnt, 1);
        rst = 1'b1;
        tick();
        check("rrun_state", state, 0);
        check("rrun_en_off", pipe_en, 0);
        check("rrun_cnt_clr", cycle_cnt, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rrun_quiet_en", pipe_en, 0);
            check("rrun_quiet_state", state, 0);
        end

        // reset mid-STEP with step_btn held
        step_btn = 1'b1;
        tick();
        check("rstep_state", state, 1);
        rst = 1'b1;
        tick();
        check("rstep_en", pipe_en, 0);
        check("rstep_halt", state, 0);
        rst = 1'b0;
        tick(); tick();
        check("rstep_quiet_en", pipe_en, 0);
        check("rstep_quiet_state", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
